// File: rtl/mm_pkg.sv
// mm_pkg: constants and types for the three-matrix multiply engine and its
// host-side stream driver. Also used by the engine bench, so it holds only
// widths, the driver state encoding and a row-major index helper.
package mm_pkg;

  localparam int DW        = 8;                    // element width
  localparam int RW        = 32;                   // result width
  localparam int MAXD      = 4;                    // max rows / max row length
  localparam int NMAT      = 3;                    // matrices per run
  localparam int RES_DEPTH = MAXD * MAXD;          // result buffer entries
  localparam int IDX_W     = $clog2(MAXD * MAXD);  // element / result index
  localparam int ROW_W     = $clog2(MAXD);         // row or column counter
  localparam int LEN_W     = $clog2(MAXD + 1);     // row length 0..MAXD
  localparam int CNT_W     = $clog2(RES_DEPTH + 1);// result count 0..16

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Row-major element index: row*MAXD + col.
  function automatic logic [IDX_W-1:0] elem_idx(input logic [ROW_W-1:0] r,
                                                input logic [ROW_W-1:0] c);
    return IDX_W'(int'(r) * MAXD + int'(c));
  endfunction

endpackage

// File: rtl/mm_result_buf.sv
// mm_result_buf: capture buffer for engine results.
//   clk, rst  : clock, synchronous active-high reset (clears count only)
//   clear     : empty the buffer at the start of a run
//   wr_en     : store wr_data at index count; dropped once count == RES_DEPTH
//   wr_data   : result word
//   rd_addr   : read index
//   count     : entries captured, saturates at RES_DEPTH
//   rd_data   : buf_mem[rd_addr], combinational
module mm_result_buf
  import mm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [CNT_W-1:0] count,
  output logic [RW-1:0]    rd_data
);

  logic [RW-1:0] buf_mem [RES_DEPTH];
  logic          full;
  logic          do_write;

  assign full     = (count == CNT_W'(RES_DEPTH));
  assign do_write = wr_en && !full && !clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (do_write) begin
      count <= count + CNT_W'(1);
    end
  end

  // Storage is deliberately not reset; count defines what is valid.
  always_ff @(posedge clk) begin
    if (do_write) begin
      buf_mem[count[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = buf_mem[rd_addr];

endmodule

// File: rtl/mm_stream_tx.sv
// mm_stream_tx: host-side transmit driver for the three-matrix multiply
// engine. Holds three int8 matrices (up to MAXD x MAXD), streams them
// row-major with col_end/row_end framing on start, then captures the
// engine's results into a readable buffer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_we/sel/addr/data element write mem[sel][addr] (IDLE only, sel 3 ignored)
//   dim_we/dim_len      row length write len[sel][addr[1:0]] (IDLE only)
//   start               single-cycle launch (ignored outside IDLE)
//   in_data/col_end/row_end  stream to the engine
//   busy/valid/out_data/ep/is_legal  engine status and results
//   tx_busy             FSM not IDLE
//   done                one-cycle pulse at end of a run
//   res_count/res_addr/res_data  result buffer count and combinational read
//   res_ep/res_illegal/res_timeout/cfg_err  run status, held until next start
//   state_dbg           current FSM state
//
// Stream handshake: while SEND, one element is presented per cycle in which
// busy is low and is considered consumed at that clock edge; a cycle with
// busy high presents zero data and flags and the position is held. Results
// are captured on each rising edge of valid while WAITing; the run ends on a
// falling edge of busy or after TIMEOUT+1 wait cycles.
module mm_stream_tx
  import mm_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [DW-1:0]    cfg_data,
  input  logic             dim_we,
  input  logic [LEN_W-1:0] dim_len,
  input  logic             start,
  output logic [DW-1:0]    in_data,
  output logic             col_end,
  output logic             row_end,
  input  logic             busy,
  input  logic             valid,
  input  logic [RW-1:0]    out_data,
  input  logic [2:0]       ep,
  input  logic             is_legal,
  output logic             tx_busy,
  output logic             done,
  output logic [CNT_W-1:0] res_count,
  input  logic [IDX_W-1:0] res_addr,
  output logic [RW-1:0]    res_data,
  output logic [2:0]       res_ep,
  output logic             res_illegal,
  output logic             res_timeout,
  output logic             cfg_err,
  output state_t           state_dbg
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  state_t           state, state_n;
  logic [1:0]       m, m_n;
  logic [ROW_W-1:0] r, r_n, c, c_n, r_inc;
  logic [WC_W-1:0]  wait_cnt, wait_n;

  logic [DW-1:0]    mem [NMAT][RES_DEPTH];
  logic [LEN_W-1:0] len [NMAT][MAXD];

  logic             valid_q, busy_q;
  logic [2:0]       res_ep_q;
  logic             illegal_q, timeout_q, cfg_err_q;

  logic [LEN_W-1:0] cur_len, dim_len_clamped;
  logic             last_col, last_row, any_empty;
  logic             valid_rise, busy_fall, capture, cfg_ok;
  logic             run_clear, set_cfg_err, set_timeout, sample_legal;

  assign cfg_ok    = (state == ST_IDLE) && (cfg_sel != 2'd3);
  assign r_inc     = r + ROW_W'(1);
  assign cur_len   = len[m][r];
  assign last_col  = (LEN_W'(c) == cur_len - LEN_W'(1));
  // A row is last if it is the final slot or the next length is zero.
  assign last_row  = (r == ROW_W'(MAXD - 1)) || (len[m][r_inc] == '0);
  assign any_empty = (len[0][0] == '0) || (len[1][0] == '0) || (len[2][0] == '0);

  assign valid_rise = valid && !valid_q;
  assign busy_fall  = busy_q && !busy;
  assign capture    = (state == ST_WAIT) && valid_rise;

  // Lengths above MAXD would let the column counter wrap without ever
  // matching, so they are clamped on write.
  assign dim_len_clamped = (dim_len > LEN_W'(MAXD)) ? LEN_W'(MAXD) : dim_len;

  always_comb begin
    state_n      = state;
    m_n          = m;
    r_n          = r;
    c_n          = c;
    wait_n       = wait_cnt;
    in_data      = '0;
    col_end      = 1'b0;
    row_end      = 1'b0;
    run_clear    = 1'b0;
    set_cfg_err  = 1'b0;
    set_timeout  = 1'b0;
    sample_legal = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          run_clear = 1'b1;
          m_n       = '0;
          r_n       = '0;
          c_n       = '0;
          wait_n    = '0;
          if (any_empty) begin
            set_cfg_err = 1'b1;
            state_n     = ST_DONE;
          end else begin
            state_n = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (!busy) begin
          in_data = mem[m][elem_idx(r, c)];
          col_end = last_col;
          row_end = last_col && last_row;
          if (last_col) begin
            if (last_row) begin
              state_n = ST_GAP;
            end else begin
              r_n = r_inc;
              c_n = '0;
            end
          end else begin
            c_n = c + ROW_W'(1);
          end
        end
      end
      ST_GAP: begin
        r_n = '0;
        c_n = '0;
        if (m == 2'd2) begin
          sample_legal = 1'b1;
          wait_n       = '0;
          state_n      = ST_WAIT;
        end else begin
          m_n     = m + 2'd1;
          state_n = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (busy_fall) begin
          state_n = ST_DONE;
        end else if (wait_cnt == WC_W'(TIMEOUT)) begin
          set_timeout = 1'b1;
          state_n     = ST_DONE;
        end else begin
          wait_n = wait_cnt + WC_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      m         <= '0;
      r         <= '0;
      c         <= '0;
      wait_cnt  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      res_ep_q  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NMAT; i++) begin
        for (int j = 0; j < MAXD; j++) begin
          len[i][j] <= '0;
        end
      end
    end else begin
      state    <= state_n;
      m        <= m_n;
      r        <= r_n;
      c        <= c_n;
      wait_cnt <= wait_n;
      valid_q  <= valid;
      busy_q   <= busy;
      if (run_clear) begin
        res_ep_q  <= '0;
        illegal_q <= 1'b0;
        timeout_q <= 1'b0;
        cfg_err_q <= 1'b0;
      end
      if (set_cfg_err)  cfg_err_q <= 1'b1;
      if (sample_legal) illegal_q <= !is_legal;
      if (capture)      res_ep_q  <= res_ep_q | ep;
      if (set_timeout)  timeout_q <= 1'b1;
      if (cfg_ok && dim_we) begin
        len[cfg_sel][cfg_addr[ROW_W-1:0]] <= dim_len_clamped;
      end
    end
  end

  // Element storage is not reset.
  always_ff @(posedge clk) begin
    if (cfg_ok && cfg_we) begin
      mem[cfg_sel][cfg_addr] <= cfg_data;
    end
  end

  mm_result_buf u_result_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (run_clear),
    .wr_en   (capture),
    .wr_data (out_data),
    .rd_addr (res_addr),
    .count   (res_count),
    .rd_data (res_data)
  );

  assign tx_busy     = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign res_ep      = res_ep_q;
  assign res_illegal = illegal_q || (res_ep_q != 3'd0);
  assign res_timeout = timeout_q;
  assign cfg_err     = cfg_err_q;
  assign state_dbg   = state;

endmodule
